// File: rtl/mshr_multi_port.sv
// Multi-port MSHR: in-order miss queue between the Dcache and the memory bus, with
// out-of-order load completion by tag, in-order retire and store-data merging.
// Optional load coalescing is enabled by defining MSHR_LOAD_COALESCE_EN.
module mshr_multi_port #(
   parameter int NUM_MISS    = 3,
   parameter int NUM_LOOKUP  = 2,
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int OFFSET_BITS = 3,
   parameter int TAG_W       = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_MISS-1:0]          miss_en,
   input  logic [NUM_MISS*ADDR_W-1:0]   miss_addr,
   input  logic [NUM_MISS*DATA_W-1:0]   miss_data,
   input  logic [NUM_MISS-1:0]          miss_is_store,
   output logic                         miss_ready,
   output logic [NUM_MISS-1:0]          miss_coalesced,
   input  logic [NUM_LOOKUP-1:0]        lookup_en,
   input  logic [NUM_LOOKUP*ADDR_W-1:0] lookup_addr,
   input  logic [NUM_LOOKUP-1:0]        lookup_is_store,
   input  logic [NUM_LOOKUP*DATA_W-1:0] lookup_wr_data,
   output logic [NUM_LOOKUP-1:0]        lookup_hit,
   output logic [NUM_LOOKUP-1:0]        lookup_data_valid,
   output logic [NUM_LOOKUP*DATA_W-1:0] lookup_data,
   output logic [1:0]                   proc2mem_command,
   output logic [ADDR_W-1:0]            proc2mem_addr,
   output logic [DATA_W-1:0]            proc2mem_data,
   input  logic [TAG_W-1:0]             mem2proc_response,
   input  logic [TAG_W-1:0]             mem2proc_tag,
   input  logic [DATA_W-1:0]            mem2proc_data,
   output logic                         fill_valid,
   output logic [ADDR_W-1:0]            fill_addr,
   output logic [DATA_W-1:0]            fill_data,
   input  logic                         fill_ack,
   output logic [$clog2(DEPTH):0]       occupancy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = IDX_W + 1;
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] NMISS_C = OCC_W'(NUM_MISS);
   localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   typedef enum logic [1:0] {ST_WAITING, ST_INPROGRESS, ST_DONE} ent_state_e;

   logic              valid_q    [DEPTH];
   logic              valid_d    [DEPTH];
   ent_state_e        state_q    [DEPTH];
   ent_state_e        state_d    [DEPTH];
   logic              is_store_q [DEPTH];
   logic              is_store_d [DEPTH];
   logic [ADDR_W-1:0] addr_q     [DEPTH];
   logic [ADDR_W-1:0] addr_d     [DEPTH];
   logic [DATA_W-1:0] data_q     [DEPTH];
   logic [DATA_W-1:0] data_d     [DEPTH];
   logic [TAG_W-1:0]  tag_q      [DEPTH];
   logic [TAG_W-1:0]  tag_d      [DEPTH];

   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W-1:0] issue_head_q, issue_head_d;
   logic [IDX_W-1:0] retire_head_q, retire_head_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic issue_vld, issue_acc, retire_vld, retire;
   logic [NUM_LOOKUP-1:0] merge_en;
   logic [IDX_W-1:0]      merge_idx [NUM_LOOKUP];

   function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return a & LINE_MASK;
   endfunction

   assign miss_ready = (DEPTH_C - occ_q) >= NMISS_C;
   assign occupancy  = occ_q;

   always_comb begin
      issue_vld        = valid_q[issue_head_q] && (state_q[issue_head_q] == ST_WAITING);
      issue_acc        = issue_vld && (mem2proc_response != '0);
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      if (issue_vld) begin
         proc2mem_command = is_store_q[issue_head_q] ? BUS_STORE : BUS_LOAD;
         proc2mem_addr    = addr_q[issue_head_q];
         if (is_store_q[issue_head_q]) begin
            proc2mem_data = data_q[issue_head_q];
         end
      end
      retire_vld = valid_q[retire_head_q] && (state_q[retire_head_q] == ST_DONE);
      fill_valid = retire_vld && !is_store_q[retire_head_q];
      fill_addr  = fill_valid ? addr_q[retire_head_q] : '0;
      fill_data  = fill_valid ? data_q[retire_head_q] : '0;
      retire     = retire_vld && (is_store_q[retire_head_q] || fill_ack);
   end

   // Scanning from retire_head towards tail lets the youngest match overwrite older ones.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] hit_idx;
      logic [IDX_W-1:0] idx;
      logic [ADDR_W-1:0] line;
      found             = 1'b0;
      hit_idx           = '0;
      idx               = '0;
      line              = '0;
      lookup_hit        = '0;
      lookup_data_valid = '0;
      lookup_data       = '0;
      merge_en          = '0;
      for (int p = 0; p < NUM_LOOKUP; p++) begin
         merge_idx[p] = '0;
      end
      for (int p = 0; p < NUM_LOOKUP; p++) begin
         found   = 1'b0;
         hit_idx = '0;
         line    = line_of(lookup_addr[p*ADDR_W +: ADDR_W]);
         for (int k = 0; k < DEPTH; k++) begin
            idx = retire_head_q + IDX_W'(k);
            if (valid_q[idx] && (addr_q[idx] == line)) begin
               found   = 1'b1;
               hit_idx = idx;
            end
         end
         if (lookup_en[p] && found) begin
            if (!lookup_is_store[p]) begin
               lookup_hit[p]                     = 1'b1;
               lookup_data_valid[p]              = (state_q[hit_idx] == ST_DONE) || is_store_q[hit_idx];
               lookup_data[p*DATA_W +: DATA_W]   = data_q[hit_idx];
            end else if (is_store_q[hit_idx] && (state_q[hit_idx] == ST_WAITING) &&
                         !(issue_acc && (hit_idx == issue_head_q))) begin
               lookup_hit[p] = 1'b1;
               merge_en[p]   = 1'b1;
               merge_idx[p]  = hit_idx;
            end
         end
      end
   end

   always_comb begin
      logic [IDX_W-1:0] slot;
      logic [OCC_W-1:0] n_alloc;
      logic             coalesce;
      valid_d        = valid_q;
      state_d        = state_q;
      is_store_d     = is_store_q;
      addr_d         = addr_q;
      data_d         = data_q;
      tag_d          = tag_q;
      tail_d         = tail_q;
      issue_head_d   = issue_head_q;
      retire_head_d  = retire_head_q;
      miss_coalesced = '0;
      slot           = tail_q;
      n_alloc        = '0;
      coalesce       = 1'b0;

      if (issue_acc) begin
         if (is_store_q[issue_head_q]) begin
            state_d[issue_head_q] = ST_DONE;
         end else begin
            state_d[issue_head_q] = ST_INPROGRESS;
            tag_d[issue_head_q]   = mem2proc_response;
         end
         issue_head_d = issue_head_q + IDX_W'(1);
      end

      // Only entries already INPROGRESS can complete, so a same-cycle issue never matches.
      for (int e = 0; e < DEPTH; e++) begin
         if ((mem2proc_tag != '0) && valid_q[e] && (state_q[e] == ST_INPROGRESS) &&
             (tag_q[e] == mem2proc_tag)) begin
            state_d[e] = ST_DONE;
            data_d[e]  = mem2proc_data;
         end
      end

      for (int p = 0; p < NUM_LOOKUP; p++) begin
         if (merge_en[p]) begin
            data_d[merge_idx[p]] = lookup_wr_data[p*DATA_W +: DATA_W];
         end
      end

      if (retire) begin
         valid_d[retire_head_q] = 1'b0;
         retire_head_d          = retire_head_q + IDX_W'(1);
      end

      if (miss_ready) begin
         for (int i = 0; i < NUM_MISS; i++) begin
            if (miss_en[i]) begin
               coalesce = 1'b0;
`ifdef MSHR_LOAD_COALESCE_EN
               if (!miss_is_store[i]) begin
                  for (int e = 0; e < DEPTH; e++) begin
                     if (valid_q[e] && !is_store_q[e] && (state_q[e] != ST_DONE) &&
                         (addr_q[e] == line_of(miss_addr[i*ADDR_W +: ADDR_W]))) begin
                        coalesce = 1'b1;
                     end
                  end
               end
`else
               coalesce = 1'b0;
`endif
               if (coalesce) begin
                  miss_coalesced[i] = 1'b1;
               end else begin
                  valid_d[slot]    = 1'b1;
                  state_d[slot]    = ST_WAITING;
                  is_store_d[slot] = miss_is_store[i];
                  addr_d[slot]     = line_of(miss_addr[i*ADDR_W +: ADDR_W]);
                  data_d[slot]     = miss_data[i*DATA_W +: DATA_W];
                  tag_d[slot]      = '0;
                  slot             = slot + IDX_W'(1);
                  n_alloc          = n_alloc + OCC_W'(1);
               end
            end
         end
      end
      tail_d = slot;
      occ_d  = occ_q + n_alloc - {{(OCC_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int e = 0; e < DEPTH; e++) begin
            valid_q[e] <= 1'b0;
            state_q[e] <= ST_WAITING;
         end
         tail_q        <= '0;
         issue_head_q  <= '0;
         retire_head_q <= '0;
         occ_q         <= '0;
      end else begin
         valid_q       <= valid_d;
         state_q       <= state_d;
         tail_q        <= tail_d;
         issue_head_q  <= issue_head_d;
         retire_head_q <= retire_head_d;
         occ_q         <= occ_d;
      end
   end

   // Payload is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clock) begin
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
   end

endmodule

// File: tb/tb_mshr_multi_port.sv
// Self-checking bench for mshr_multi_port: bus requests and fills are checked against
// scoreboard queues filled as misses are driven.
module tb_mshr_multi_port;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef struct { logic [1:0] cmd; logic [63:0] addr; logic [63:0] data; } req_t;
   typedef struct { logic [63:0] addr; logic [63:0] data; } fill_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    miss_en;
   logic [191:0]  miss_addr;
   logic [191:0]  miss_data;
   logic [2:0]    miss_is_store;
   logic          miss_ready;
   logic [2:0]    miss_coalesced;
   logic [1:0]    lookup_en;
   logic [127:0]  lookup_addr;
   logic [1:0]    lookup_is_store;
   logic [127:0]  lookup_wr_data;
   logic [1:0]    lookup_hit;
   logic [1:0]    lookup_data_valid;
   logic [127:0]  lookup_data;
   logic [1:0]    proc2mem_command;
   logic [63:0]   proc2mem_addr;
   logic [63:0]   proc2mem_data;
   logic [3:0]    mem2proc_response;
   logic [3:0]    mem2proc_tag;
   logic [63:0]   mem2proc_data;
   logic          fill_valid;
   logic [63:0]   fill_addr;
   logic [63:0]   fill_data;
   logic          fill_ack;
   logic [4:0]    occupancy;

   int    n_tests = 0;
   int    n_fail  = 0;
   req_t  issue_q[$];
   fill_t fill_q[$];
   logic [191:0] va, vd;
   req_t  rr;

   always #5 clock = ~clock;

   mshr_multi_port dut (
      .clock(clock), .reset(reset),
      .miss_en(miss_en), .miss_addr(miss_addr), .miss_data(miss_data),
      .miss_is_store(miss_is_store), .miss_ready(miss_ready), .miss_coalesced(miss_coalesced),
      .lookup_en(lookup_en), .lookup_addr(lookup_addr), .lookup_is_store(lookup_is_store),
      .lookup_wr_data(lookup_wr_data), .lookup_hit(lookup_hit),
      .lookup_data_valid(lookup_data_valid), .lookup_data(lookup_data),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
      .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
      .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
      .fill_ack(fill_ack), .occupancy(occupancy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive_miss(input logic [2:0] en, input logic [2:0] st,
                             input logic [191:0] a, input logic [191:0] d, input logic accept);
      req_t r;
      miss_en       = en;
      miss_is_store = st;
      miss_addr     = a;
      miss_data     = d;
      settle();
      check("miss_ready", {63'd0, miss_ready}, {63'd0, accept});
      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
               r.cmd  = st[i] ? BUS_STORE : BUS_LOAD;
               r.addr = a[i*64 +: 64] & ~64'h7;
               r.data = st[i] ? d[i*64 +: 64] : 64'h0;
               issue_q.push_back(r);
            end
         end
      end
      tick();
      miss_en = '0;
   endtask

   task automatic issue_one(input logic [3:0] tag);
      req_t r;
      settle();
      if (issue_q.size() == 0) begin
         check("issue_q_nonempty", 64'd0, 64'd1);
         return;
      end
      r = issue_q.pop_front();
      check("issue_cmd", {62'd0, proc2mem_command}, {62'd0, r.cmd});
      check("issue_addr", proc2mem_addr, r.addr);
      if (r.cmd == BUS_STORE) check("issue_st_data", proc2mem_data, r.data);
      mem2proc_response = tag;
      tick();
      mem2proc_response = '0;
   endtask

   task automatic complete(input logic [3:0] tag, input logic [63:0] d);
      mem2proc_tag  = tag;
      mem2proc_data = d;
      tick();
      mem2proc_tag  = '0;
   endtask

   task automatic model_merge(input logic [63:0] d);
      req_t r;
      r = issue_q.pop_back();
      r.data = d;
      issue_q.push_back(r);
   endtask

   task automatic retire_fill();
      fill_t f;
      int    n;
      n = 0;
      settle();
      while (!fill_valid && n < 20) begin
         tick();
         settle();
         n++;
      end
      check("fill_seen", {63'd0, fill_valid}, 64'd1);
      if (fill_q.size() == 0) begin
         check("fill_q_nonempty", 64'd0, 64'd1);
         return;
      end
      f = fill_q.pop_front();
      check("fill_addr", fill_addr, f.addr);
      check("fill_data", fill_data, f.data);
      tick();
      settle();
      check("fill_hold", {63'd0, fill_valid}, 64'd1);
      check("fill_hold_addr", fill_addr, f.addr);
      fill_ack = 1'b1;
      tick();
      fill_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      miss_en = '0; miss_addr = '0; miss_data = '0; miss_is_store = '0;
      lookup_en = 2'b11; lookup_addr = {64'h100, 64'h100}; lookup_is_store = '0;
      lookup_wr_data = '0; mem2proc_response = '0; mem2proc_tag = '0;
      mem2proc_data = '0; fill_ack = 1'b0;
      #1 reset = 1'b0;
      tick(); tick(); settle();
      check("rst_occ", {59'd0, occupancy}, 64'd0);
      check("rst_ready", {63'd0, miss_ready}, 64'd1);
      check("rst_cmd", {62'd0, proc2mem_command}, {62'd0, BUS_NONE});
      check("rst_fill", {63'd0, fill_valid}, 64'd0);
      check("rst_lk_hit", {62'd0, lookup_hit}, 64'd0);
      check("rst_lk_dv", {62'd0, lookup_data_valid}, 64'd0);
      lookup_en = '0;
      reset = 1'b1;
      tick();

      // Two loads, out-of-order completion, in-order fill
      drive_miss(3'b101, 3'b000, {64'h208, 64'h999, 64'h100}, '0, 1'b1);
      fill_q.push_back('{64'h100, 64'hCAFE});
      fill_q.push_back('{64'h208, 64'hBEEF});
      settle();
      check("occ_after_alloc", {59'd0, occupancy}, 64'd2);
      issue_one(4'd3);
      issue_one(4'd5);
      settle();
      check("cmd_idle", {62'd0, proc2mem_command}, {62'd0, BUS_NONE});
      lookup_en = 2'b11; lookup_is_store = 2'b10; lookup_addr = {64'h100, 64'h20C};
      settle();
      check("lk_pending_hit", {62'd0, lookup_hit}, 64'd1);
      check("lk_pending_dv", {62'd0, lookup_data_valid}, 64'd0);
      lookup_en = '0;
      tick();
      complete(4'd5, 64'hBEEF);
      settle();
      check("no_fill_ooo", {63'd0, fill_valid}, 64'd0);
      complete(4'd3, 64'hCAFE);
      lookup_en = 2'b01; lookup_is_store = 2'b00; lookup_addr = {64'h0, 64'h100};
      settle();
      check("lk_done_hit", {62'd0, lookup_hit}, 64'd1);
      check("lk_done_dv", {62'd0, lookup_data_valid}, 64'd1);
      check("lk_done_data", lookup_data[63:0], 64'hCAFE);
      lookup_en = '0;
      retire_fill();
      retire_fill();
      settle();
      check("occ_after_fills", {59'd0, occupancy}, 64'd0);
      tick();

      // Fill to 14 entries of stores, drop a miss, then drain
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < 3; i++) begin
            va[i*64 +: 64] = 64'h1000 + 64'((c*3 + i) * 8);
            vd[i*64 +: 64] = 64'((c*3 + i) + 1);
         end
         drive_miss((c < 4) ? 3'b111 : 3'b011, 3'b111, va, vd, 1'b1);
      end
      settle();
      check("occ_full14", {59'd0, occupancy}, 64'd14);
      check("ready_low", {63'd0, miss_ready}, 64'd0);
      drive_miss(3'b111, 3'b111, va, vd, 1'b0);
      settle();
      check("occ_after_drop", {59'd0, occupancy}, 64'd14);
      issue_one(4'd1);
      tick();
      settle();
      check("occ_after_retire", {59'd0, occupancy}, 64'd13);
      check("ready_restored", {63'd0, miss_ready}, 64'd1);
      while (issue_q.size() > 0) issue_one(4'd1);
      tick(); tick(); settle();
      check("occ_drained", {59'd0, occupancy}, 64'd0);
      tick();

      // Store merge and forwarding
      drive_miss(3'b001, 3'b001, {128'h0, 64'h300}, {128'h0, 64'h11}, 1'b1);
      lookup_en = 2'b01; lookup_is_store = 2'b01;
      lookup_addr = {64'h0, 64'h301}; lookup_wr_data = {64'h0, 64'h22};
      settle();
      check("lk_st_merge_hit", {62'd0, lookup_hit}, 64'd1);
      tick();
      lookup_en = '0;
      model_merge(64'h22);
      lookup_en = 2'b11; lookup_is_store = 2'b01; lookup_addr = {64'h300, 64'h400};
      settle();
      check("lk_mix_hit", {62'd0, lookup_hit}, 64'd2);
      check("lk_mix_dv", {62'd0, lookup_data_valid}, 64'd2);
      check("lk_fwd_store", lookup_data[127:64], 64'h22);
      lookup_en = '0;
      tick();
      issue_one(4'd2);
      drive_miss(3'b001, 3'b001, {128'h0, 64'h500}, {128'h0, 64'h55}, 1'b1);
      lookup_en = 2'b11; lookup_is_store = 2'b11;
      lookup_addr = {64'h500, 64'h500}; lookup_wr_data = {64'h44, 64'h33};
      settle();
      check("lk_dual_hit", {62'd0, lookup_hit}, 64'd3);
      tick();
      model_merge(64'h44);
      lookup_en = 2'b01; lookup_is_store = 2'b01;
      lookup_addr = {64'h0, 64'h500}; lookup_wr_data = {64'h0, 64'h66};
      mem2proc_response = 4'd2;
      settle();
      check("lk_st_blocked", {62'd0, lookup_hit}, 64'd0);
      rr = issue_q.pop_front();
      check("blk_issue_cmd", {62'd0, proc2mem_command}, {62'd0, rr.cmd});
      check("blk_issue_data", proc2mem_data, rr.data);
      tick();
      mem2proc_response = '0;
      lookup_en = 2'b01; lookup_is_store = 2'b00;
      settle();
      check("lk_after_blk", lookup_data[63:0], 64'h44);
      lookup_en = '0;
      tick(); tick(); settle();
      check("occ_after_stores", {59'd0, occupancy}, 64'd0);
      tick();

      // Reset while loads are in flight; a late tag must not fill
      drive_miss(3'b111, 3'b000, {64'h710, 64'h708, 64'h700}, '0, 1'b1);
      issue_one(4'd1);
      issue_one(4'd2);
      issue_one(4'd3);
      settle();
      reset = 1'b0;
      settle();
      check("mid_rst_occ", {59'd0, occupancy}, 64'd0);
      check("mid_rst_cmd", {62'd0, proc2mem_command}, {62'd0, BUS_NONE});
      check("mid_rst_ready", {63'd0, miss_ready}, 64'd1);
      tick();
      reset = 1'b1;
      complete(4'd3, 64'hDEAD);
      settle();
      check("late_tag_fill", {63'd0, fill_valid}, 64'd0);
      tick();
      settle();
      check("late_tag_fill2", {63'd0, fill_valid}, 64'd0);
      check("late_tag_occ", {59'd0, occupancy}, 64'd0);

      check("issue_q_left", 64'(issue_q.size()), 64'd0);
      check("fill_q_left", 64'(fill_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
